// File: rtl/fib_pkg.sv
// Shared FIB defaults, engine state encoding and route payload layout.
package fib_pkg;

    localparam int unsigned FIB_PREFIX_W = 64;
    localparam int unsigned FIB_LEN_W    = 6;
    localparam int unsigned FIB_HASH_W   = 10;
    localparam int unsigned FIB_FACE_W   = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWRd,
        StWChk,
        StLRd,
        StLChk,
        StResp
    } fib_state_e;

    typedef struct packed {
        logic [FIB_LEN_W-1:0]  len;
        logic [FIB_FACE_W-1:0] face;
    } fib_entry_t;

endpackage

// File: rtl/fib_hash.sv
// Name-prefix hash: keep the top len bits, XOR-fold into HASH_W-bit chunks, mix in len.
// Chunk i covers bits [i*HASH_W +: HASH_W]; the topmost chunk is zero-padded.
module fib_hash import fib_pkg::*; #(
    parameter int unsigned PREFIX_W = FIB_PREFIX_W,
    parameter int unsigned LEN_W    = FIB_LEN_W,
    parameter int unsigned HASH_W   = FIB_HASH_W
) (
    input  logic [PREFIX_W-1:0] prefix,
    input  logic [LEN_W-1:0]    len,
    output logic [HASH_W-1:0]   idx
);

    localparam int unsigned NCHUNK = (PREFIX_W + HASH_W - 1) / HASH_W;

    logic [PREFIX_W-1:0]      mask;
    logic [NCHUNK*HASH_W-1:0] padded;

    always_comb begin
        // len == 0 yields an all-zero mask, so every default route hashes to len alone
        mask   = ~({PREFIX_W{1'b1}} >> len);
        padded = '0;
        padded[PREFIX_W-1:0] = prefix & mask;
        idx = HASH_W'(len);
        for (int i = 0; i < NCHUNK; i++) begin
            idx = idx ^ padded[i*HASH_W +: HASH_W];
        end
    end

endmodule

// File: rtl/fib_lpm_engine.sv
// Hashed longest-prefix-match FIB: route insert/delete port and a probing lookup port.
module fib_lpm_engine import fib_pkg::*; #(
    parameter int unsigned PREFIX_W = FIB_PREFIX_W,
    parameter int unsigned LEN_W    = FIB_LEN_W,
    parameter int unsigned HASH_W   = FIB_HASH_W,
    parameter int unsigned FACE_W   = FIB_FACE_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                ins_valid,
    output logic                ins_ready,
    input  logic                ins_del,
    input  logic [PREFIX_W-1:0] ins_prefix,
    input  logic [LEN_W-1:0]    ins_len,
    input  logic [FACE_W-1:0]   ins_face,
    output logic                ins_done,
    output logic                ins_fail,
    input  logic                lkp_valid,
    output logic                lkp_ready,
    input  logic [PREFIX_W-1:0] lkp_prefix,
    input  logic [LEN_W-1:0]    lkp_len,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_hit,
    output logic [LEN_W-1:0]    res_len,
    output logic [FACE_W-1:0]   res_face,
    output logic [PREFIX_W-1:0] res_prefix,
    output logic [HASH_W:0]     entry_count,
    output logic                busy
);

    localparam int unsigned DEPTH = 2 ** HASH_W;
    localparam int unsigned CNT_W = HASH_W + 1;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [FACE_W-1:0] face;
    } entry_t;

    fib_state_e          state_q, state_d;
    logic [DEPTH-1:0]    valid_q, valid_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                del_q, del_d;
    logic [PREFIX_W-1:0] prefix_q, prefix_d;
    // Route length for insert/delete, current probe length for lookups
    logic [LEN_W-1:0]    len_q, len_d;
    logic [FACE_W-1:0]   face_q, face_d;
    logic                res_hit_q, res_hit_d;
    logic [LEN_W-1:0]    res_len_q, res_len_d;
    logic [FACE_W-1:0]   res_face_q, res_face_d;

    logic [HASH_W-1:0]   idx;
    entry_t              mem [DEPTH];
    entry_t              rd_q;
    logic                rd_en;
    logic                wr_en;
    logic                slot_v;
    logic                len_match;

    fib_hash #(
        .PREFIX_W (PREFIX_W),
        .LEN_W    (LEN_W),
        .HASH_W   (HASH_W)
    ) u_hash (
        .prefix (prefix_q),
        .len    (len_q),
        .idx    (idx)
    );

    // Payload RAM: synchronous read, no reset; occupancy lives in valid_q
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_q <= mem[idx];
        end
        if (wr_en) begin
            mem[idx] <= {len_q, face_q};
        end
    end

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        count_d    = count_q;
        del_d      = del_q;
        prefix_d   = prefix_q;
        len_d      = len_q;
        face_d     = face_q;
        res_hit_d  = res_hit_q;
        res_len_d  = res_len_q;
        res_face_d = res_face_q;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        ins_done   = 1'b0;
        ins_fail   = 1'b0;
        ins_ready  = 1'b0;
        lkp_ready  = 1'b0;
        slot_v     = valid_q[idx];
        len_match  = (rd_q.len == len_q);

        unique case (state_q)
            StIdle: begin
                ins_ready = !clr;
                lkp_ready = !clr && !ins_valid;
                if (clr) begin
                    valid_d = '0;
                    count_d = '0;
                end else if (ins_valid) begin
                    del_d    = ins_del;
                    prefix_d = ins_prefix;
                    len_d    = ins_len;
                    face_d   = ins_face;
                    state_d  = StWRd;
                end else if (lkp_valid) begin
                    prefix_d = lkp_prefix;
                    len_d    = lkp_len;
                    state_d  = StLRd;
                end
            end
            StWRd: begin
                rd_en   = 1'b1;
                state_d = StWChk;
            end
            StWChk: begin
                ins_done = 1'b1;
                state_d  = StIdle;
                if (!del_q) begin
                    if (!slot_v) begin
                        wr_en        = 1'b1;
                        valid_d[idx] = 1'b1;
                        count_d      = count_q + CNT_W'(1);
                    end else if (len_match) begin
                        wr_en = 1'b1;
                    end else begin
                        ins_fail = 1'b1;
                    end
                end else if (slot_v && len_match) begin
                    valid_d[idx] = 1'b0;
                    count_d      = count_q - CNT_W'(1);
                end else begin
                    ins_fail = 1'b1;
                end
            end
            StLRd: begin
                rd_en   = 1'b1;
                state_d = StLChk;
            end
            StLChk: begin
                if (slot_v && len_match) begin
                    res_hit_d  = 1'b1;
                    res_len_d  = len_q;
                    res_face_d = rd_q.face;
                    state_d    = StResp;
                end else if (len_q == '0) begin
                    res_hit_d  = 1'b0;
                    res_len_d  = '0;
                    res_face_d = '0;
                    state_d    = StResp;
                end else begin
                    len_d   = len_q - LEN_W'(1);
                    state_d = StLRd;
                end
            end
            StResp: begin
                if (res_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            valid_q    <= '0;
            count_q    <= '0;
            del_q      <= 1'b0;
            prefix_q   <= '0;
            len_q      <= '0;
            face_q     <= '0;
            res_hit_q  <= 1'b0;
            res_len_q  <= '0;
            res_face_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            count_q    <= count_d;
            del_q      <= del_d;
            prefix_q   <= prefix_d;
            len_q      <= len_d;
            face_q     <= face_d;
            res_hit_q  <= res_hit_d;
            res_len_q  <= res_len_d;
            res_face_q <= res_face_d;
        end
    end

    assign res_valid   = (state_q == StResp);
    assign busy        = (state_q != StIdle);
    assign res_hit     = res_hit_q;
    assign res_len     = res_len_q;
    assign res_face    = res_face_q;
    assign res_prefix  = prefix_q;
    assign entry_count = count_q;

endmodule

// File: tb/tb_fib_lpm_engine.sv
// Directed bench for fib_lpm_engine: route ops, LPM probing, clr arbitration, backpressure, reset.
module tb_fib_lpm_engine;

    localparam logic [63:0] P_AB   = 64'hAB00_0000_0000_0000;
    localparam logic [63:0] P_ABCD = 64'hABCD_0000_0000_0000;
    localparam logic [63:0] P_UNR  = 64'h1234_5678_9ABC_DEF0;
    // len 4 with top nibble 4 folds to index 0, same slot as the default route
    localparam logic [63:0] P_COL  = 64'h4000_0000_0000_0000;

    logic        clk;
    logic        rst;
    logic        clr;
    logic        ins_valid;
    logic        ins_ready;
    logic        ins_del;
    logic [63:0] ins_prefix;
    logic [5:0]  ins_len;
    logic [3:0]  ins_face;
    logic        ins_done;
    logic        ins_fail;
    logic        lkp_valid;
    logic        lkp_ready;
    logic [63:0] lkp_prefix;
    logic [5:0]  lkp_len;
    logic        res_valid;
    logic        res_ready;
    logic        res_hit;
    logic [5:0]  res_len;
    logic [3:0]  res_face;
    logic [63:0] res_prefix;
    logic [10:0] entry_count;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    fib_lpm_engine u_dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_del     (ins_del),
        .ins_prefix  (ins_prefix),
        .ins_len     (ins_len),
        .ins_face    (ins_face),
        .ins_done    (ins_done),
        .ins_fail    (ins_fail),
        .lkp_valid   (lkp_valid),
        .lkp_ready   (lkp_ready),
        .lkp_prefix  (lkp_prefix),
        .lkp_len     (lkp_len),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_hit     (res_hit),
        .res_len     (res_len),
        .res_face    (res_face),
        .res_prefix  (res_prefix),
        .entry_count (entry_count),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input string tag, input logic del, input logic [63:0] pfx,
                         input logic [5:0] len, input logic [3:0] face,
                         input logic exp_fail, input int exp_cnt);
        ins_del    = del;
        ins_prefix = pfx;
        ins_len    = len;
        ins_face   = face;
        ins_valid  = 1'b1;
        #1;
        chk({tag, ".ins_ready"}, 64'(ins_ready), 64'd1);
        step();
        ins_valid = 1'b0;
        chk({tag, ".c1_busy"}, 64'(busy), 64'd1);
        chk({tag, ".c1_done"}, 64'(ins_done), 64'd0);
        step();
        chk({tag, ".c2_done"}, 64'(ins_done), 64'd1);
        chk({tag, ".c2_fail"}, 64'(ins_fail), 64'(exp_fail));
        step();
        chk({tag, ".c3_done"}, 64'(ins_done), 64'd0);
        chk({tag, ".c3_busy"}, 64'(busy), 64'd0);
        chk({tag, ".count"}, 64'(entry_count), 64'(exp_cnt));
    endtask

    task automatic do_lkp(input string tag, input logic [63:0] pfx, input logic [5:0] len,
                          input logic exp_hit, input logic [5:0] exp_len,
                          input logic [3:0] exp_face, input int exp_cyc, input int hold);
        int cyc;
        lkp_prefix = pfx;
        lkp_len    = len;
        lkp_valid  = 1'b1;
        res_ready  = (hold == 0);
        #1;
        chk({tag, ".lkp_ready"}, 64'(lkp_ready), 64'd1);
        step();
        lkp_valid = 1'b0;
        cyc = 1;
        while (!res_valid && cyc < 200) begin
            step();
            cyc++;
        end
        chk({tag, ".cycle"}, 64'(cyc), 64'(exp_cyc));
        chk({tag, ".hit"}, 64'(res_hit), 64'(exp_hit));
        chk({tag, ".len"}, 64'(res_len), 64'(exp_len));
        chk({tag, ".face"}, 64'(res_face), 64'(exp_face));
        chk({tag, ".prefix"}, res_prefix, pfx);
        for (int h = 0; h < hold; h++) begin
            step();
            chk({tag, ".hold_valid"}, 64'(res_valid), 64'd1);
            chk({tag, ".hold_face"}, 64'(res_face), 64'(exp_face));
            chk({tag, ".hold_len"}, 64'(res_len), 64'(exp_len));
            chk({tag, ".hold_busy"}, 64'(busy), 64'd1);
            chk({tag, ".hold_rdy"}, 64'({ins_ready, lkp_ready}), 64'd0);
        end
        res_ready = 1'b1;
        step();
        chk({tag, ".done_busy"}, 64'(busy), 64'd0);
        chk({tag, ".done_valid"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        rst        = 1'b0;
        clr        = 1'b0;
        ins_valid  = 1'b0;
        ins_del    = 1'b0;
        ins_prefix = '0;
        ins_len    = '0;
        ins_face   = '0;
        lkp_valid  = 1'b0;
        lkp_prefix = '0;
        lkp_len    = '0;
        res_ready  = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.count", 64'(entry_count), 64'd0);
        chk("rst.res_valid", 64'(res_valid), 64'd0);
        chk("rst.res_fields", {56'd0, res_hit, res_len, res_face[0]}, 64'd0);
        chk("rst.res_face", 64'(res_face), 64'd0);
        chk("rst.res_prefix", res_prefix, 64'd0);
        chk("rst.done_fail", 64'({ins_done, ins_fail}), 64'd0);
        chk("rst.readies", 64'({ins_ready, lkp_ready}), 64'd3);

        do_op("ins_ab", 1'b0, P_AB, 6'd8, 4'd3, 1'b0, 1);
        do_lkp("lkp_ab", P_ABCD, 6'd16, 1'b1, 6'd8, 4'd3, 19, 0);

        do_op("ins_dflt", 1'b0, 64'd0, 6'd0, 4'd1, 1'b0, 2);
        do_lkp("lkp_dflt", P_UNR, 6'd5, 1'b1, 6'd0, 4'd1, 13, 0);
        do_op("del_dflt", 1'b1, 64'd0, 6'd0, 4'd0, 1'b0, 1);
        do_lkp("lkp_nodflt", P_UNR, 6'd5, 1'b0, 6'd0, 4'd0, 13, 0);
        do_op("del_again", 1'b1, 64'd0, 6'd0, 4'd0, 1'b1, 1);

        do_op("upd_ab", 1'b0, P_AB, 6'd8, 4'd7, 1'b0, 1);
        do_lkp("lkp_upd", P_ABCD, 6'd16, 1'b1, 6'd8, 4'd7, 19, 0);
        do_op("ins_dflt2", 1'b0, 64'd0, 6'd0, 4'd1, 1'b0, 2);
        do_op("ins_col", 1'b0, P_COL, 6'd4, 4'd5, 1'b1, 2);
        do_lkp("lkp_col", P_COL, 6'd4, 1'b1, 6'd0, 4'd1, 11, 0);

        // clr beats a simultaneous insert and lookup; the insert wins next cycle
        clr        = 1'b1;
        ins_valid  = 1'b1;
        ins_del    = 1'b0;
        ins_prefix = P_AB;
        ins_len    = 6'd8;
        ins_face   = 4'd2;
        lkp_valid  = 1'b1;
        lkp_prefix = P_ABCD;
        lkp_len    = 6'd16;
        #1;
        chk("clr.ins_ready", 64'(ins_ready), 64'd0);
        chk("clr.lkp_ready", 64'(lkp_ready), 64'd0);
        step();
        clr = 1'b0;
        chk("clr.count", 64'(entry_count), 64'd0);
        chk("clr.busy", 64'(busy), 64'd0);
        #1;
        chk("clr.next_ins_ready", 64'(ins_ready), 64'd1);
        chk("clr.next_lkp_ready", 64'(lkp_ready), 64'd0);
        do_op("clr_ins", 1'b0, P_AB, 6'd8, 4'd2, 1'b0, 1);
        do_lkp("clr_lkp", P_ABCD, 6'd16, 1'b1, 6'd8, 4'd2, 19, 0);
        do_lkp("clr_nodflt", P_UNR, 6'd5, 1'b0, 6'd0, 4'd0, 13, 0);

        do_lkp("hold", P_ABCD, 6'd16, 1'b1, 6'd8, 4'd2, 19, 5);

        // reset in the middle of a lookup
        lkp_prefix = P_ABCD;
        lkp_len    = 6'd16;
        lkp_valid  = 1'b1;
        res_ready  = 1'b1;
        step();
        lkp_valid = 1'b0;
        chk("mrst.inflight_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("mrst.res_valid", 64'(res_valid), 64'd0);
        chk("mrst.count", 64'(entry_count), 64'd0);
        chk("mrst.busy", 64'(busy), 64'd0);
        chk("mrst.res_hit", 64'(res_hit), 64'd0);
        do_lkp("mrst_lkp_ab", P_ABCD, 6'd16, 1'b0, 6'd0, 4'd0, 35, 0);
        do_lkp("mrst_lkp_col", P_COL, 6'd4, 1'b0, 6'd0, 4'd0, 11, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fib_lpm_engine.md
# fib_lpm_engine

Parametrised next-generation FIB for the NDN router. It stores name-prefix routes (prefix, length, outgoing face) in a hashed table. It serves longest-prefix-match lookups by probing from the requested length down to length 0, and returns both the matched length and the face. It sits between the PIT (lookup requester) and the interface logic, with a separate insert/delete port driven by route management.

## Interface
- PREFIX_W, 64, prefix width in bits; must equal 2**LEN_W
- LEN_W, 6, length field width; length = number of significant leading prefix bits, 0..2**LEN_W-1
- HASH_W, 10, table index width; DEPTH = 2**HASH_W entries
- FACE_W, 4, outgoing face id width
- clk  in  1  sole clock, rising edge
- rst  in  1  reset, synchronous, active-low
- clr  in  1  level request to invalidate all entries; sampled only in IDLE
- ins_valid / ins_ready  in / out  1  route op handshake
- ins_del  in  1  0 = insert/update, 1 = delete
- ins_prefix, ins_len, ins_face  in  PREFIX_W, LEN_W, FACE_W  route op operands
- ins_done  out  1  one-cycle pulse, op completed
- ins_fail  out  1  valid with ins_done
  - insert: slot held by a different length
  - delete: no matching entry
- lkp_valid / lkp_ready  in / out  1  lookup handshake
- lkp_prefix, lkp_len  in  PREFIX_W, LEN_W  lookup key
- res_valid / res_ready  out / in  1  result handshake
- res_hit, res_len, res_face, res_prefix  out  1, LEN_W, FACE_W, PREFIX_W  lookup result; res_prefix echoes the key
- entry_count  out  HASH_W+1  number of valid entries
- busy  out  1  high when not in IDLE

## Operation
- Storage: per-entry valid bit in flops (DEPTH bits); {len, face} payload in synchronous-read RAM.
- Hash (combinational):
  - m = prefix with all bits below the top len bits zeroed.
  - idx = XOR of all HASH_W-bit chunks of m (last chunk zero-padded) XOR len zero-extended to HASH_W.
- States: IDLE, W_RD, W_CHK, L_RD, L_CHK, RESP.
- IDLE arbitration, in priority order: clr > insert > lookup.
  - ins_ready = IDLE & !clr.
  - lkp_ready = IDLE & !clr & !ins_valid.
- clr in IDLE: all valid bits cleared; entry_count ← 0 on the same edge; state stays IDLE.
- Insert/delete: on accept, latch operands and idx, then go to W_RD (RAM read). In W_CHK, with v = valid[idx] and L = stored len:
  - insert, !v: write, set valid, count+1.
  - insert, v & L==ins_len: overwrite face, count unchanged.
  - insert, v & L!=ins_len: no write, ins_fail=1.
  - delete, v & L==ins_len: clear valid, count−1.
  - delete, otherwise: ins_fail=1.
  - In all cases ins_done=1 in W_CHK, then go to IDLE.
- Lookup:
  - On accept, latch key and set probe length p = lkp_len.
  - L_RD reads at hash(prefix, p).
  - L_CHK: hit if valid & stored len == p.
    - hit → RESP with res_hit=1, res_len=p, res_face=stored face.
    - miss & p==0 → RESP with res_hit=0, res_len=0, res_face=0.
    - otherwise p ← p−1, back to L_RD.
- RESP: res_valid held with stable fields until res_ready; IDLE on the handshake cycle.
- Length-0 entry is the default route.
- Hash aliasing between different prefixes of equal length is accepted. A false hit is possible and is resolved by the PIT/interface.
- Reset (rst=0 at an edge, any state): state IDLE, all valid bits 0, entry_count 0, busy 0, ins_done 0, ins_fail 0, res_valid 0, res_hit 0, res_len 0, res_face 0, res_prefix 0. Any in-flight operation is dropped and RAM contents are don't-care. ins_ready and lkp_ready follow from IDLE and the inputs.

## Timing
- Cycle 0 = accept cycle.
- Insert/delete: W_RD in cycle 1; W_CHK in cycle 2 with ins_done; the write lands at the end of cycle 2; IDLE in cycle 3.
- Lookup hit at probe k (k=0 at lkp_len): L_RD in cycle 1+2k, L_CHK in cycle 2+2k, res_valid from cycle 3+2k.
- Full miss: res_valid at cycle 2·lkp_len+3.
- No pipelining: one operation in flight; new ops are accepted only in IDLE.
- A lookup accepted the cycle after ins_done sees the updated table.
- entry_count and valid bits change only at edges in W_CHK or on clr.

## Structure
- Shared package fib_pkg holds the PREFIX_W, LEN_W, HASH_W and FACE_W defaults, the state enum and the entry payload typedef {len, face}.
- Sub-module fib_hash: combinational masking + XOR fold; reused by the PIT.
- The RAM is an inferred simple dual-port array inside the engine.

## Test plan
- Reset, then insert (0xAB00…0, len 8, face 3) → ins_done at cycle 2, ins_fail=0, entry_count=1. Then lookup (0xABCD…, len 16) → res_hit=1, res_len=8, res_face=3, res_valid at cycle 19.
- Insert default route (len 0, face 1); lookup an unrelated prefix with len 5 → hit, res_len=0, res_face=1, res_valid at cycle 13. Delete it, repeat → res_hit=0, res_len=0, res_face=0.
- Re-insert an existing (prefix, len) with face 7 → count unchanged, subsequent lookup returns face 7. Force an idx collision with a different len → ins_fail=1, table unchanged.
- clr, ins_valid and lkp_valid asserted together in IDLE → table cleared, ins_ready=lkp_ready=0 that cycle. Next cycle the insert is accepted before the lookup.
- Hold res_ready=0 for 5 cycles → res_* stable, busy=1, both ready outputs 0. Pull rst low during L_RD → res_valid 0, entry_count 0, all lookups then miss.
